// File: rtl/mlp_sample_sequencer.sv
// Streams feature beats into the classifier input bus, holds it for SETTLE cycles,
// then returns the captured prediction with a sample index. SEQ_DOUBLEBUF_EN adds a shadow buffer.
module mlp_sample_sequencer #(
   parameter int NUM_A    = 8,
   parameter int WIDTH_A  = 4,
   parameter int OUTWIDTH = 4,
   parameter int SETTLE   = 2,
   parameter int IDXW     = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH_A-1:0]         in_data,
   output logic [NUM_A*WIDTH_A-1:0]   inp,
   input  logic [OUTWIDTH-1:0]        pred_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [OUTWIDTH-1:0]        out_data,
   output logic [IDXW-1:0]            out_idx,
   output logic                       busy
);

   localparam logic [1:0] ST_LOAD   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_HOLD   = 2'd2;

   localparam int BW = $clog2(NUM_A + 1);
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [BW-1:0] LAST_BEAT   = BW'(NUM_A - 1);
   localparam logic [SW-1:0] LAST_SETTLE = SW'(SETTLE - 1);

   generate
      if (SETTLE < 1) begin : g_bad_settle
         $error("mlp_sample_sequencer: SETTLE must be >= 1");
      end
   endgenerate

   logic [1:0]                         state_q, state_d;
   logic [BW-1:0]                      beat_cnt_q, beat_cnt_d;
   logic [SW-1:0]                      settle_cnt_q, settle_cnt_d;
   logic [NUM_A-1:0][WIDTH_A-1:0]      inp_q, inp_d;
   logic [OUTWIDTH-1:0]                out_data_q, out_data_d;
   logic [IDXW-1:0]                    out_idx_q, out_idx_d;
   logic                               out_valid_q, out_valid_d;
   logic [IDXW-1:0]                    sample_cnt_q, sample_cnt_d;
   logic                               beat;

`ifdef SEQ_DOUBLEBUF_EN
   // beat_cnt_q counts shadow words; NUM_A means the shadow is full and waiting
   logic [NUM_A-1:0][WIDTH_A-1:0]      shadow_q, shadow_d, shadow_wr;
   logic                               full_now;

   assign in_ready = (beat_cnt_q != BW'(NUM_A));
`else
   assign in_ready = (state_q == ST_LOAD);
`endif

   assign beat      = in_valid && in_ready;
   assign inp       = inp_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign busy      = !((state_q == ST_LOAD) && (beat_cnt_q == '0));

   always_comb begin
      state_d      = state_q;
      beat_cnt_d   = beat_cnt_q;
      settle_cnt_d = settle_cnt_q;
      inp_d        = inp_q;
      out_data_d   = out_data_q;
      out_idx_d    = out_idx_q;
      out_valid_d  = out_valid_q;
      sample_cnt_d = sample_cnt_q;

`ifdef SEQ_DOUBLEBUF_EN
      shadow_d  = shadow_q;
      shadow_wr = shadow_q;
      for (int k = 0; k < NUM_A; k++) begin
         if (beat && (beat_cnt_q == BW'(k))) shadow_wr[k] = in_data;
      end
      full_now = (beat_cnt_q == BW'(NUM_A)) || (beat && (beat_cnt_q == LAST_BEAT));
      if (beat) begin
         shadow_d   = shadow_wr;
         beat_cnt_d = beat_cnt_q + 1'b1;
      end
`else
      if (beat) begin
         for (int k = 0; k < NUM_A; k++) begin
            if (beat_cnt_q == BW'(k)) inp_d[k] = in_data;
         end
         beat_cnt_d = beat_cnt_q + 1'b1;
      end
`endif

      case (state_q)
         ST_LOAD: begin
            if (beat && (beat_cnt_q == LAST_BEAT)) begin
`ifdef SEQ_DOUBLEBUF_EN
               inp_d    = shadow_wr;
               shadow_d = '0;
`endif
               beat_cnt_d   = '0;
               settle_cnt_d = '0;
               state_d      = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (settle_cnt_q == LAST_SETTLE) begin
               out_data_d  = pred_in;
               out_idx_d   = sample_cnt_q;
               out_valid_d = 1'b1;
               state_d     = ST_HOLD;
            end else begin
               settle_cnt_d = settle_cnt_q + 1'b1;
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               out_valid_d  = 1'b0;
               sample_cnt_d = sample_cnt_q + 1'b1;
               state_d      = ST_LOAD;
`ifdef SEQ_DOUBLEBUF_EN
               // a shadow that is (or just became) full skips LOAD entirely
               if (full_now) begin
                  inp_d        = shadow_wr;
                  shadow_d     = '0;
                  beat_cnt_d   = '0;
                  settle_cnt_d = '0;
                  state_d      = ST_SETTLE;
               end
`endif
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_LOAD;
         beat_cnt_q   <= '0;
         settle_cnt_q <= '0;
         inp_q        <= '0;
         out_data_q   <= '0;
         out_idx_q    <= '0;
         out_valid_q  <= 1'b0;
         sample_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         beat_cnt_q   <= beat_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         inp_q        <= inp_d;
         out_data_q   <= out_data_d;
         out_idx_q    <= out_idx_d;
         out_valid_q  <= out_valid_d;
         sample_cnt_q <= sample_cnt_d;
      end
   end

`ifdef SEQ_DOUBLEBUF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) shadow_q <= '0;
      else        shadow_q <= shadow_d;
   end
`endif

endmodule

// File: tb/tb_mlp_sample_sequencer.sv
// Directed bench for mlp_sample_sequencer (NUM_A=4, WIDTH_A=4, SETTLE=2, IDXW=2);
// the classifier stub returns the sum of the four features mod 16.
module tb_mlp_sample_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_data;
   logic [15:0] inp;
   logic [3:0]  pred_in;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_data;
   logic [1:0]  out_idx;
   logic        busy;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;

   mlp_sample_sequencer #(
      .NUM_A(4), .WIDTH_A(4), .OUTWIDTH(4), .SETTLE(2), .IDXW(2)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .inp(inp), .pred_in(pred_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_idx(out_idx), .busy(busy)
   );

   assign pred_in = inp[3:0] + inp[7:4] + inp[11:8] + inp[15:12];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // log every rising out_valid: cycle, data, index
   logic       ov_prev = 1'b0;
   int         nrise = 0;
   int         rise_cyc [16];
   logic [3:0] rise_dat [16];
   logic [1:0] rise_idx [16];
   always @(negedge clk) begin
      if (out_valid && !ov_prev && nrise < 16) begin
         rise_cyc[nrise] = cyc;
         rise_dat[nrise] = out_data;
         rise_idx[nrise] = out_idx;
         nrise++;
      end
      ov_prev = out_valid;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // present one beat and hold it until accepted
   task automatic send(input logic [3:0] v);
      int n = 0;
      in_valid = 1'b1;
      in_data  = v;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n == 50) chk("send_timeout", 32'(n), 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_feats(input logic [15:0] f);
      for (int k = 0; k < 4; k++) send(f[k*4 +: 4]);
   endtask

   task automatic wait_result(input string tag, input logic [3:0] ed, input logic [1:0] ei);
      int n = 0;
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_latency"}, 32'(n), 32'd2);
      chk({tag, "_data"}, 32'(out_data), 32'(ed));
      chk({tag, "_idx"}, 32'(out_idx), 32'(ei));
   endtask

   task automatic run_sample(input string tag, input logic [15:0] f,
                             input logic [3:0] ed, input logic [1:0] ei);
      send_feats(f);
      chk({tag, "_inp"}, 32'(inp), 32'(f));
      wait_result(tag, ed, ei);
      @(posedge clk); #1;
      chk({tag, "_drop"}, 32'(out_valid), 32'd0);
      chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

`ifdef SEQ_DOUBLEBUF_EN
   logic [3:0] strm [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1, 4'd1, 4'd1, 4'd2};
`endif

   initial begin
      int c0, hs;
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready_during", 32'(in_ready), 32'd1);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_inp", 32'(inp), 32'd0);
      chk("rst_out_idx", 32'(out_idx), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);

`ifndef SEQ_DOUBLEBUF_EN
      out_ready = 1'b1;
      run_sample("basic", 16'h4321, 4'hA, 2'd0);
      chk("basic_idle", 32'(busy), 32'd0);

      // backpressure: result must hold, beats must be refused
      out_ready = 1'b0;
      send_feats(16'h8642);
      wait_result("bp", 4'h4, 2'd1);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = 4'hF;
         @(posedge clk); #1;
         chk("bp_hold_valid", 32'(out_valid), 32'd1);
         chk("bp_hold_data", 32'(out_data), 32'h4);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      chk("bp_inp_frozen", 32'(inp), 32'h8642);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_drop", 32'(out_valid), 32'd0);
      chk("bp_rdy", 32'(in_ready), 32'd1);

      // first beat overwrites only word 0; older words persist
      send(4'h3);
      chk("partial_inp", 32'(inp), 32'h8643);
      chk("partial_busy", 32'(busy), 32'd1);
      send(4'h0); send(4'h0); send(4'h0);
      chk("next_inp", 32'(inp), 32'h0003);
      wait_result("next", 4'h3, 2'd2);
      @(posedge clk); #1;
      run_sample("s3", 16'h1111, 4'h4, 2'd3);
      run_sample("s4", 16'hFFFF, 4'hC, 2'd0);

      // reset mid-sample discards the partial sample and the index
      send(4'h9); send(4'h9);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_inp", 32'(inp), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      run_sample("w0", 16'h5555, 4'h4, 2'd0);
      run_sample("w1", 16'h0001, 4'h1, 2'd1);
      run_sample("w2", 16'h00F1, 4'h0, 2'd2);
      run_sample("w3", 16'h7000, 4'h7, 2'd3);
      run_sample("w4", 16'h2222, 4'h8, 2'd0);
      repeat (8) @(posedge clk);
      #1;
      chk("result_count", 32'(nrise), 32'd10);
      for (int k = 6; k < 10; k++)
         chk("throughput", 32'(rise_cyc[k] - rise_cyc[k-1]), 32'd7);
`else
      out_ready = 1'b1;
      c0 = cyc;
      in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_data = strm[i];
         #0;
         chk("db_in_ready", 32'(in_ready), 32'd1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      // next sample fills the shadow while B is held
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 4'(i + 2);
         chk("db_fill_ready", 32'(in_ready), 32'd1);
         @(posedge clk); #1;
      end
      in_data = 4'h5;
      out_ready = 1'b1;
      @(posedge clk); #1;
      hs = cyc;
      in_valid = 1'b0;
      chk("db_same_edge_inp", 32'(inp), 32'h5432);
      chk("db_same_edge_drop", 32'(out_valid), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      chk("db_count", 32'(nrise), 32'd3);
      chk("db_first_lat", 32'(rise_cyc[0] - c0), 32'd6);
      chk("db_spacing", 32'(rise_cyc[1] - rise_cyc[0]), 32'd4);
      chk("db_same_edge_lat", 32'(rise_cyc[2] - hs), 32'd2);
      chk("db_d0", 32'(rise_dat[0]), 32'hA);
      chk("db_d1", 32'(rise_dat[1]), 32'h5);
      chk("db_d2", 32'(rise_dat[2]), 32'hE);
      chk("db_i0", 32'(rise_idx[0]), 32'd0);
      chk("db_i1", 32'(rise_idx[1]), 32'd1);
      chk("db_i2", 32'(rise_idx[2]), 32'd2);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
